instr_decode_stage: RTL and testbench

Pipeline stage between instruction fetch and the ALU/execute stage.
- Accepts 32-bit instruction words plus PC over a valid/ready handshake.
- Decodes each word into the ALU operation code, register indices, immediate and jump target consumed by execute.
- Holds results in a registered output with a 2-entry skid buffer so that in_ready is driven from a flop, not combinationally from out_ready.

---
 rtl/nova_pkg.sv | 53 +++++
 rtl/instr_decoder.sv | 68 ++++++
 rtl/instr_decode_stage.sv | 142 ++++++++++++++
 tb/tb_instr_decode_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nova_pkg.sv
// Shared decode definitions: ALU op codes, opcode/funct values, field positions, decoded struct.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nova_pkg;

    // ALU operation codes handed to execute
    localparam logic [5:0] ALU_ADD     = 6'h00;
    localparam logic [5:0] ALU_SUB     = 6'h01;
    localparam logic [5:0] ALU_AND     = 6'h02;
    localparam logic [5:0] ALU_OR      = 6'h03;
    localparam logic [5:0] ALU_XOR     = 6'h04;
    localparam logic [5:0] ALU_ADDI    = 6'h10;
    localparam logic [5:0] ALU_ILLEGAL = 6'h3F;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    // R-type function codes
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int TGT_MSB = 25;
    localparam int FN_MSB  = 5;

    // Decoded instruction; one copy lives in each of the main and skid entries
    typedef struct packed {
        logic [5:0]  alu_op;
        logic [4:0]  rs_idx;
        logic [4:0]  rt_idx;
        logic [4:0]  wr_idx;
        logic        reg_write;
        logic [15:0] imm16;
        logic [25:0] target;
        logic        is_jump;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of a 32-bit instruction word into the execute-stage struct.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the result is captured.
module instr_decoder
    import nova_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd_idx;

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign funct  = instr[FN_MSB:0];
    assign rd_idx = instr[RD_MSB:RD_LSB];

    // Field extraction is unconditional; opcode/funct select op, destination and flags
    always_comb begin
        dec           = '0;
        dec.rs_idx    = instr[RS_MSB:RS_LSB];
        dec.rt_idx    = instr[RT_MSB:RT_LSB];
        dec.imm16     = instr[IMM_MSB:0];
        dec.target    = instr[TGT_MSB:0];
        dec.alu_op    = ALU_ILLEGAL;
        dec.illegal   = 1'b1;
        dec.wr_idx    = 5'd0;
        dec.reg_write = 1'b0;
        dec.is_jump   = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  dec.alu_op = ALU_ADD;
                    FN_SUB:  dec.alu_op = ALU_SUB;
                    FN_AND:  dec.alu_op = ALU_AND;
                    FN_OR:   dec.alu_op = ALU_OR;
                    FN_XOR:  dec.alu_op = ALU_XOR;
                    default: dec.alu_op = ALU_ILLEGAL;
                endcase
                if (dec.alu_op != ALU_ILLEGAL) begin
                    dec.illegal   = 1'b0;
                    dec.wr_idx    = rd_idx;
                    dec.reg_write = 1'b1;
                end
            end
            OP_ADDI: begin
                dec.alu_op    = ALU_ADDI;
                dec.illegal   = 1'b0;
                dec.wr_idx    = instr[RT_MSB:RT_LSB];
                dec.reg_write = 1'b1;
            end
            OP_J: begin
                dec.alu_op  = ALU_ADD;
                dec.illegal = 1'b0;
                dec.is_jump = 1'b1;
            end
            default: ;
        endcase

        // r0 is hard-wired zero, so writing it back is suppressed
        if (dec.wr_idx == 5'd0) begin
            dec.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: fetch word -> registered decoded instruction with a 2-entry (main + skid) buffer.
// Latency: 1 cycle from accept to out_valid when main is empty or draining.
// Backpressure: in_ready is a flop equal to !skid_valid; flush drops everything held.
module instr_decode_stage
    import nova_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_alu_op,
    output logic [4:0]       out_rs_idx,
    output logic [4:0]       out_rt_idx,
    output logic [4:0]       out_wr_idx,
    output logic             out_reg_write,
    output logic [15:0]      out_imm16,
    output logic [25:0]      out_target,
    output logic             out_is_jump,
    output logic             out_illegal,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] illegal_cnt
);

    dec_t            in_dec;
    dec_t            main_dec;
    dec_t            skid_dec;
    logic [PC_W-1:0] main_pc;
    logic [PC_W-1:0] skid_pc;
    logic            main_vld;
    logic            skid_vld;
    logic            in_rdy_q;

    logic            xfer;
    logic            main_load;
    logic            main_vld_nxt;
    logic            skid_vld_nxt;
    logic            main_from_skid;
    logic            main_from_in;
    logic            skid_from_in;
    logic            cnt_inc;

    instr_decoder u_decoder (
        .instr (in_instr),
        .dec   (in_dec)
    );

    assign xfer      = in_valid && in_rdy_q;
    assign main_load = !main_vld || out_ready;

    // Occupancy next-state and load steering; flush overrides all movement
    always_comb begin
        main_vld_nxt   = main_vld;
        skid_vld_nxt   = skid_vld;
        main_from_skid = 1'b0;
        main_from_in   = 1'b0;
        skid_from_in   = 1'b0;
        if (flush) begin
            main_vld_nxt = 1'b0;
            skid_vld_nxt = 1'b0;
        end else if (main_load) begin
            if (skid_vld) begin
                // in_ready is low whenever skid is full, so no input can arrive here
                main_from_skid = 1'b1;
                main_vld_nxt   = 1'b1;
                skid_vld_nxt   = 1'b0;
            end else if (xfer) begin
                main_from_in = 1'b1;
                main_vld_nxt = 1'b1;
            end else begin
                main_vld_nxt = 1'b0;
            end
        end else if (xfer) begin
            skid_from_in = 1'b1;
            skid_vld_nxt = 1'b1;
        end
    end

    // Illegal words are counted only when execute actually takes them
    assign cnt_inc = !flush && main_vld && out_ready && main_dec.illegal
                     && (illegal_cnt != {CNT_W{1'b1}});

    // Valid bits, registered in_ready and the saturating illegal counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_vld    <= 1'b0;
            skid_vld    <= 1'b0;
            in_rdy_q    <= 1'b1;
            illegal_cnt <= '0;
        end else begin
            main_vld <= main_vld_nxt;
            skid_vld <= skid_vld_nxt;
            in_rdy_q <= !skid_vld_nxt;
            if (cnt_inc) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end
    end

    // Payload registers only move on a load, which keeps outputs stable under stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_dec <= '0;
            main_pc  <= '0;
            skid_dec <= '0;
            skid_pc  <= '0;
        end else begin
            if (main_from_skid) begin
                main_dec <= skid_dec;
                main_pc  <= skid_pc;
            end else if (main_from_in) begin
                main_dec <= in_dec;
                main_pc  <= in_pc;
            end
            if (skid_from_in) begin
                skid_dec <= in_dec;
                skid_pc  <= in_pc;
            end
        end
    end

    assign in_ready      = in_rdy_q;
    assign out_valid     = main_vld;
    assign out_alu_op    = main_dec.alu_op;
    assign out_rs_idx    = main_dec.rs_idx;
    assign out_rt_idx    = main_dec.rt_idx;
    assign out_wr_idx    = main_dec.wr_idx;
    assign out_reg_write = main_dec.reg_write;
    assign out_imm16     = main_dec.imm16;
    assign out_target    = main_dec.target;
    assign out_is_jump   = main_dec.is_jump;
    assign out_illegal   = main_dec.illegal;
    assign out_pc        = main_pc;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
// Latency: n/a.
// Backpressure: randomized out_ready and flush exercise the skid path.
module tb_instr_decode_stage;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_instr = 32'd0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [5:0]       out_alu_op;
    logic [4:0]       out_rs_idx;
    logic [4:0]       out_rt_idx;
    logic [4:0]       out_wr_idx;
    logic             out_reg_write;
    logic [15:0]      out_imm16;
    logic [25:0]      out_target;
    logic             out_is_jump;
    logic             out_illegal;
    logic [PC_W-1:0]  out_pc;
    logic [CNT_W-1:0] illegal_cnt;

    instr_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_op    (out_alu_op),
        .out_rs_idx    (out_rs_idx),
        .out_rt_idx    (out_rt_idx),
        .out_wr_idx    (out_wr_idx),
        .out_reg_write (out_reg_write),
        .out_imm16     (out_imm16),
        .out_target    (out_target),
        .out_is_jump   (out_is_jump),
        .out_illegal   (out_illegal),
        .out_pc        (out_pc),
        .illegal_cnt   (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  alu;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic        rw;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        j;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    exp_t mq[$];
    int   mcnt = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the encoding table
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        exp_t e;
        int op, fn;
        op    = int'(w >> 26);
        fn    = int'(w & 32'h3F);
        e.rs  = 5'((w >> 21) & 32'h1F);
        e.rt  = 5'((w >> 16) & 32'h1F);
        e.imm = 16'(w & 32'hFFFF);
        e.tgt = 26'(w & 32'h3FFFFFF);
        e.pc  = pc;
        e.alu = 6'h3F; e.ill = 1'b1; e.wr = 5'd0; e.rw = 1'b0; e.j = 1'b0;
        if (op == 0 && (fn == 'h20 || fn == 'h22 || fn == 'h24 || fn == 'h25 || fn == 'h26)) begin
            e.alu = (fn == 'h20) ? 6'h00 : (fn == 'h22) ? 6'h01 : (fn == 'h24) ? 6'h02 :
                    (fn == 'h25) ? 6'h03 : 6'h04;
            e.ill = 1'b0;
            e.wr  = 5'((w >> 11) & 32'h1F);
            e.rw  = 1'b1;
        end else if (op == 8) begin
            e.alu = 6'h10; e.ill = 1'b0; e.wr = e.rt; e.rw = 1'b1;
        end else if (op == 2) begin
            e.alu = 6'h00; e.ill = 1'b0; e.j = 1'b1;
        end
        if (e.wr == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    // Model: up to two held words, front one visible; called once per rising edge
    task automatic model_step();
        bit rdy;
        if (rst) begin
            mq.delete();
            mcnt = 0;
            return;
        end
        rdy = (mq.size() < 2);
        if (flush) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && out_ready) begin
                if (mq[0].ill && mcnt < CNT_MAX) mcnt++;
                void'(mq.pop_front());
            end
            if (in_valid && rdy) mq.push_back(ref_decode(in_instr, in_pc));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] w, input logic [31:0] pc,
                         input bit ordy, input bit fl);
        in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [5:0]  fns [5];
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h26;
        w = $urandom;
        case ($urandom_range(0, 5))
            0: w = {6'h00, w[25:6], fns[$urandom_range(0, 4)]};
            1: w = {6'h00, w[25:0]};
            2: w = {6'h08, w[25:0]};
            3: w = {6'h02, w[25:0]};
            4: w = {6'h00, w[25:16], 5'd0, w[10:6], fns[$urandom_range(0, 4)]};
            default: ;
        endcase
        return w;
    endfunction

    // Every cycle: DUT outputs against the model's front entry and occupancy
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("in_ready", 128'(in_ready), 128'(mq.size() < 2));
            chk("out_valid", 128'(out_valid), 128'(mq.size() > 0));
            chk("illegal_cnt", 128'(illegal_cnt), 128'(mcnt));
            if (mq.size() > 0) begin
                chk("payload",
                    128'({out_alu_op, out_rs_idx, out_rt_idx, out_wr_idx, out_reg_write,
                          out_imm16, out_target, out_is_jump, out_illegal, out_pc}),
                    128'(mq[0]));
            end
        end
    end

    initial begin
        #12 rst = 1'b0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_cnt", 128'(illegal_cnt), 128'(0));
        chk("rst_alu_op", 128'(out_alu_op), 128'(0));
        chk("rst_pc", 128'(out_pc), 128'(0));
        chk_en = 1'b1;

        // add r3,r1,r2
        drive(1, 32'h00221820, 32'h100, 1, 0); tick();
        chk("add_valid", 128'(out_valid), 128'(1));
        chk("add_fields", 128'({out_alu_op, out_rs_idx, out_rt_idx, out_wr_idx, out_reg_write}),
            128'({6'h00, 5'd1, 5'd2, 5'd3, 1'b1}));
        // addi r5,r4,-1
        drive(1, 32'h2085FFFF, 32'h104, 1, 0); tick();
        chk("addi_fields", 128'({out_alu_op, out_rs_idx, out_wr_idx, out_imm16, out_reg_write}),
            128'({6'h10, 5'd4, 5'd5, 16'hFFFF, 1'b1}));
        // j 0x100
        drive(1, 32'h08000100, 32'h108, 1, 0); tick();
        chk("j_fields", 128'({out_is_jump, out_target, out_reg_write}),
            128'({1'b1, 26'h0000100, 1'b0}));
        // two illegal encodings
        drive(1, 32'hFC000000, 32'h10C, 1, 0); tick();
        chk("ill1", 128'({out_illegal, out_alu_op}), 128'({1'b1, 6'h3F}));
        drive(1, 32'h00000001, 32'h110, 1, 0); tick();
        chk("ill2", 128'({out_illegal, out_alu_op}), 128'({1'b1, 6'h3F}));
        drive(0, 32'h0, 32'h0, 1, 0); tick();
        chk("ill_cnt2", 128'(illegal_cnt), 128'(2));
        chk("drained", 128'(out_valid), 128'(0));

        // Backpressure: three offered, two accepted, outputs held
        drive(1, 32'h00221820, 32'h200, 0, 0); tick();
        chk("bp_in_ready1", 128'(in_ready), 128'(1));
        drive(1, 32'h00432022, 32'h204, 0, 0); tick();
        chk("bp_in_ready0", 128'(in_ready), 128'(0));
        chk("bp_hold_pc1", 128'(out_pc), 128'(32'h200));
        drive(1, 32'h00643024, 32'h208, 0, 0); tick();
        chk("bp_hold_pc2", 128'({out_pc, out_alu_op, out_wr_idx}), 128'({32'h200, 6'h00, 5'd3}));
        chk("bp_still_full", 128'(in_ready), 128'(0));
        drive(0, 32'h0, 32'h0, 1, 0); tick();
        chk("bp_second", 128'({out_valid, out_pc, out_alu_op}), 128'({1'b1, 32'h204, 6'h01}));
        chk("bp_in_ready_back", 128'(in_ready), 128'(1));
        tick();
        chk("bp_empty", 128'(out_valid), 128'(0));

        // Flush with both entries full and an input offered
        drive(1, 32'hFC000000, 32'h300, 0, 0); tick();
        drive(1, 32'hFC000000, 32'h304, 0, 0); tick();
        drive(1, 32'h00221820, 32'h308, 1, 1); tick();
        chk("fl_out_valid", 128'(out_valid), 128'(0));
        chk("fl_in_ready", 128'(in_ready), 128'(1));
        chk("fl_cnt", 128'(illegal_cnt), 128'(2));
        drive(1, 32'h00221820, 32'h30C, 1, 0); tick();
        chk("fl_next", 128'({out_valid, out_pc}), 128'({1'b1, 32'h30C}));
        drive(0, 32'h0, 32'h0, 1, 0); tick();

        // Random traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                drive(1, rand_instr(), $urandom, 0, 0); tick();
                drive(1, rand_instr(), $urandom, 0, 0);
                @(posedge clk);
                model_step();
                #3 rst = 1'b1;
                #1;
                chk("arst_out_valid", 128'(out_valid), 128'(0));
                chk("arst_in_ready", 128'(in_ready), 128'(1));
                chk("arst_cnt", 128'(illegal_cnt), 128'(0));
                chk("arst_payload", 128'({out_alu_op, out_rs_idx, out_rt_idx, out_wr_idx,
                     out_reg_write, out_imm16, out_target, out_is_jump, out_illegal, out_pc}),
                    128'(0));
                model_step();
                tick();
                #1 rst = 1'b0;
            end
            drive($urandom_range(0, 9) < 7, rand_instr(), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
            tick();
        end
        drive(0, 32'h0, 32'h0, 1, 0);
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
